// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing helpers for the fetch_q slice.
//   fq_entry_t : one instruction-queue entry {inst, err} at the default
//                16-bit instruction width. Queue users with another ILEN
//                declare the same layout locally and pass it to fetch_fifo
//                as a type parameter.
//   fq_inc     : PC increment in bytes for a given instruction width.
//   fq_ptr_w   : read/write pointer width for a queue depth.
//   fq_cnt_w   : width of a counter that must hold 0..depth inclusive.
package fetch_pkg;

    localparam int unsigned FQ_ILEN = 16;

    typedef struct packed {
        logic [FQ_ILEN-1:0] inst;
        logic               err;
    } fq_entry_t;

    function automatic int unsigned fq_inc(input int unsigned ilen);
        return ilen / 8;
    endfunction

    function automatic int unsigned fq_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned fq_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of DEPTH entries of type T.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : empties the FIFO this cycle (push/pop ignored)
//   push, wdata : write an entry at the tail
//   pop         : remove the head entry
//   head        : current head entry (meaningless while empty)
//   count       : number of valid entries, 0..DEPTH
//   full, empty : status flags derived from count
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fq_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  T                           wdata,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = fq_ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is allowed only when the head leaves the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset: validity is tracked by
    // the pointers and count alone, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_q.sv
// fetch_q: decoupled instruction-fetch stage.
//   clk, rst_n                      : clock, synchronous active-low reset
//   redirect_valid, redirect_pc     : flush everything and restart at redirect_pc
//   imem_req_valid/ready/addr       : sequential request channel to instruction memory
//   imem_rsp_valid/data/err         : in-order responses, arbitrary latency
//   ifid_valid/ready/pc/inst/err    : queue head presented to decode
// A credit scheme (queue entries + requests in flight <= QDEPTH) guarantees
// every issued request a queue slot, so responses are never back-pressured.
module fetch_q
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 16,
    parameter int unsigned     ILEN     = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            ifid_valid,
    input  logic            ifid_ready,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_inst,
    output logic            ifid_err
);

    localparam int unsigned     INC     = fq_inc(ILEN);
    localparam int unsigned     ALIGN_W = $clog2(INC);
    localparam int unsigned     CW      = fq_cnt_w(QDEPTH);
    localparam logic [XLEN-1:0] INC_X   = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'((1 << ALIGN_W) - 1);

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic            err;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] head_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW:0]     used;
    logic            q_full;
    logic            q_empty;
    logic            req_fire;
    logic            dropping;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_aligned;
    entry_t          rsp_entry;
    entry_t          head_entry;

    assign used             = {1'b0, q_count} + {1'b0, inflight};
    assign redirect_aligned = redirect_pc & ALIGN_M;
    assign dropping         = (drop_cnt != '0);

    assign imem_req_valid = rst_n & ~redirect_valid & (used < (CW+1)'(QDEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Responses owed to a flushed stream are discarded; a response arriving in
    // the redirect cycle itself is also discarded (it is the oldest in flight).
    assign push      = rst_n & imem_rsp_valid & ~dropping & ~redirect_valid;
    assign rsp_entry = '{inst: imem_rsp_data, err: imem_rsp_err};

    assign ifid_valid = rst_n & ~q_empty & ~redirect_valid;
    assign pop        = ifid_valid & ifid_ready;
    assign ifid_pc    = rst_n ? head_pc : RESET_PC;
    assign ifid_inst  = head_entry.inst;
    assign ifid_err   = head_entry.err;

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata (rsp_entry),
        .pop   (pop),
        .head  (head_entry),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            head_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_aligned;
            head_pc  <= redirect_aligned;
            // Everything still outstanding belongs to the old stream.
            inflight <= inflight - CW'(imem_rsp_valid);
            drop_cnt <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc      <= pc + INC_X;
            if (pop)      head_pc <= head_pc + INC_X;
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // The credit scheme must never let a response meet a full queue.
    no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_q.sv
module tb_fetch_q;

    localparam int unsigned XLEN     = 16;
    localparam int unsigned ILEN     = 16;
    localparam int unsigned QDEPTH   = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] INC      = 16'd2;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_inst;
    logic        ifid_err;

    fetch_q #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_pc        (ifid_pc),
        .ifid_inst      (ifid_inst),
        .ifid_err       (ifid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: every accepted request, in order, with its answer and
    // whether a redirect has made it stale.
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        err;
        int          due;
        bit          stale;
    } mreq_t;

    // What decode should see, in program order.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        logic        err;
    } qent_t;

    mreq_t       outq[$];
    qent_t       mq[$];
    logic [15:0] exp_pc;
    logic [15:0] exp_head;
    int          cyc;
    int          pop_cnt;
    int          checks;
    int          failures;

    int lat_min, lat_max, rdy_pct, rsp_pct, ifid_pct, err_pct;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy,
                             input int rsp, input int ifr, input int errp);
        lat_min  = lmin;
        lat_max  = lmax;
        rdy_pct  = rdy;
        rsp_pct  = rsp;
        ifid_pct = ifr;
        err_pct  = errp;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model to match the coming edge.
    task automatic run_cycle(input logic rst_v, input logic redir_v, input logic [15:0] redir_addr);
        logic  rsp_fire;
        logic  exp_rv;
        logic  exp_iv;
        mreq_t m;
        qent_t e;

        @(negedge clk);
        rst_n          = rst_v;
        redirect_valid = redir_v;
        redirect_pc    = redir_addr;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        ifid_ready     = ($urandom_range(99) < ifid_pct);
        rsp_fire = rst_v && (outq.size() > 0) && ($urandom_range(99) < rsp_pct);
        if (rsp_fire) rsp_fire = (outq[0].due <= cyc);
        imem_rsp_valid = rsp_fire;
        imem_rsp_data  = rsp_fire ? outq[0].data : 16'($urandom);
        imem_rsp_err   = rsp_fire ? outq[0].err  : 1'($urandom);
        #2;

        exp_rv = 1'b0;
        exp_iv = 1'b0;
        if (!rst_v) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
            check("rst_ifid_pc", 32'(ifid_pc), 32'(RESET_PC));
        end else begin
            exp_rv = !redir_v && ((mq.size() + outq.size()) < QDEPTH);
            exp_iv = !redir_v && (mq.size() > 0);
            check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) check("req_addr", 32'(imem_req_addr), 32'(exp_pc));
            check("ifid_valid", 32'(ifid_valid), 32'(exp_iv));
            check("ifid_pc", 32'(ifid_pc), 32'(exp_head));
            if (exp_iv) begin
                check("ifid_pc_order", 32'(ifid_pc), 32'(mq[0].pc));
                check("ifid_inst", 32'(ifid_inst), 32'(mq[0].data));
                check("ifid_err", 32'(ifid_err), 32'(mq[0].err));
            end
        end

        if (!rst_v) begin
            outq.delete();
            mq.delete();
            exp_pc   = RESET_PC;
            exp_head = RESET_PC;
        end else if (redir_v) begin
            if (rsp_fire) void'(outq.pop_front());
            foreach (outq[i]) outq[i].stale = 1'b1;
            mq.delete();
            exp_pc   = redir_addr & 16'hFFFE;
            exp_head = redir_addr & 16'hFFFE;
        end else begin
            if (exp_iv && ifid_ready) begin
                void'(mq.pop_front());
                exp_head = exp_head + INC;
                pop_cnt++;
            end
            if (rsp_fire) begin
                m = outq.pop_front();
                if (!m.stale) begin
                    e.pc   = m.addr;
                    e.data = m.data;
                    e.err  = m.err;
                    mq.push_back(e);
                end
            end
            if (exp_rv && imem_req_ready) begin
                m.addr  = exp_pc;
                m.data  = 16'($urandom);
                m.err   = ($urandom_range(99) < err_pct);
                m.due   = cyc + $urandom_range(lat_max, lat_min);
                m.stale = 1'b0;
                outq.push_back(m);
                exp_pc = exp_pc + INC;
            end
        end
        cyc++;
    endtask

    initial begin
        int pops_before;

        checks         = 0;
        failures       = 0;
        cyc            = 0;
        pop_cnt        = 0;
        exp_pc         = RESET_PC;
        exp_head       = RESET_PC;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        ifid_ready     = 1'b0;
        set_knobs(1, 1, 100, 100, 100, 0);

        repeat (3) run_cycle(1'b0, 1'b0, 16'h0);

        // Streaming at latency 1 with everything ready: one instruction per cycle.
        repeat (10) run_cycle(1'b1, 1'b0, 16'h0);
        pops_before = pop_cnt;
        repeat (20) run_cycle(1'b1, 1'b0, 16'h0);
        check("throughput_l1", 32'(pop_cnt - pops_before), 32'd20);

        // Decode stalled: credits cap requests at the queue depth, then drain.
        set_knobs(1, 1, 100, 100, 0, 0);
        repeat (10) run_cycle(1'b1, 1'b0, 16'h0);
        set_knobs(1, 1, 100, 100, 100, 0);
        repeat (10) run_cycle(1'b1, 1'b0, 16'h0);

        // Latency 3 with requests in flight, then an unaligned redirect.
        set_knobs(3, 3, 100, 100, 100, 20);
        repeat (6) run_cycle(1'b1, 1'b0, 16'h0);
        run_cycle(1'b1, 1'b1, 16'h0101);
        repeat (12) run_cycle(1'b1, 1'b0, 16'h0);

        // Address wrap at the top of the PC space.
        set_knobs(1, 2, 100, 100, 100, 20);
        run_cycle(1'b1, 1'b1, 16'hFFFA);
        repeat (12) run_cycle(1'b1, 1'b0, 16'h0);

        // Random traffic with random redirects.
        set_knobs(1, 6, 70, 70, 60, 12);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) run_cycle(1'b1, 1'b1, 16'($urandom));
            else                        run_cycle(1'b1, 1'b0, 16'h0);
        end

        // Reset mid-stream with a full queue, then restart at RESET_PC.
        set_knobs(1, 1, 100, 100, 0, 10);
        repeat (12) run_cycle(1'b1, 1'b0, 16'h0);
        check("queue_filled", 32'(mq.size()), 32'(QDEPTH));
        run_cycle(1'b0, 1'b0, 16'h0);
        set_knobs(1, 3, 90, 90, 90, 10);
        repeat (30) run_cycle(1'b1, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
